// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family: width limits and
// binary/Gray conversion functions sized for the widest legal counter.
package gray_pkg;

  // Widest counter supported; narrower counters zero-extend into these helpers.
  localparam int GRAY_MAX_W = 16;
  localparam int GRAY_MIN_W = 2;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Zero-extended upper bits leave the result correct for any narrower width.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Terminal count (all ones) for a given width.
  function automatic gray_word_t max_count(input int width);
    gray_word_t m;
    m = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Pure combinational binary-to-Gray encoder of parameterised width.
module gray_encode
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  // The MSB passes straight through; every lower bit XORs with its upper neighbour.
  assign o_gray[WIDTH-1] = i_bin[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH-1; gi++) begin : g_bit
      assign o_gray[gi] = i_bin[gi] ^ i_bin[gi+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Parameterised up/down Gray-code counter with synchronous load, wrap or
// saturate at terminal count, sticky overflow/underflow flags and a
// one-cycle wrap strobe. The count is held in binary; Gray is derived
// combinationally so Output changes with zero latency after the edge.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,  // legal range 2..16
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_ovf_event;
  logic             w_unf_event;

  assign w_at_max  = (r_count == MAX);
  assign w_at_zero = (r_count == '0);

  // Load overrides counting, so a step only happens when no load is pending.
  assign w_step_up = En && !Load && Up;
  assign w_step_dn = En && !Load && !Up;

  // Terminal-count attempts raise the flags and the wrap strobe in both modes.
  assign w_ovf_event = w_step_up && w_at_max;
  assign w_unf_event = w_step_dn && w_at_zero;

  // Next-count mux: load, then step with wrap or saturate at the ends, else hold.
  always_comb begin
    w_count_next = r_count;
    if (Load) begin
      w_count_next = LoadVal;
    end else if (w_step_up) begin
      if (w_at_max) w_count_next = SATURATE ? MAX : '0;
      else          w_count_next = r_count + 1'b1;
    end else if (w_step_dn) begin
      if (w_at_zero) w_count_next = SATURATE ? '0 : MAX;
      else           w_count_next = r_count - 1'b1;
    end
  end

  // Count, sticky flags and wrap strobe; a set event beats a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_overflow  <= w_ovf_event | (r_overflow  & ~FlagClr);
      r_underflow <= w_unf_event | (r_underflow & ~FlagClr);
      r_wrap      <= w_ovf_event | w_unf_event;
    end
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .i_bin  (r_count),
    .o_gray (Output)
  );

  assign BinOut    = r_count;
  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;
  assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: a wrapping 3-bit counter and a saturating 4-bit
// counter share one stimulus stream and are compared every cycle against an
// arithmetic reference model; directed scenarios add literal expectations.
module tb_gray_counter_n;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, En = 1'b0, Up = 1'b0, Load = 1'b0, FlagClr = 1'b0;
  logic [3:0] LoadVal = 4'd0;

  logic [2:0] out3, bin3;
  logic       ovf3, unf3, wrp3;
  logic [3:0] out4, bin4;
  logic       ovf4, unf4, wrp4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = WIDTH 3 wrap, index 1 = WIDTH 4 saturate.
  int m_cnt[2], m_ovf[2], m_unf[2], m_wrp[2];
  int m_wid[2] = '{3, 4};
  int m_sat[2] = '{0, 1};
  logic [15:0] prev_out[2];
  bit          have_prev = 1'b0;

  always #5 Clk = ~Clk;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut3 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal[2:0]), .FlagClr(FlagClr),
    .Output(out3), .BinOut(bin3), .Overflow(ovf3), .Underflow(unf3), .Wrap(wrp3)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) dut4 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal), .FlagClr(FlagClr),
    .Output(out4), .BinOut(bin4), .Overflow(ovf4), .Underflow(unf4), .Wrap(wrp4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Compare one instance against the model, plus the single-bit-change property.
  task automatic check_inst(input int i, input logic [15:0] o, input logic [15:0] b,
                            input logic ov, input logic un, input logic wr,
                            input bit ham_ok);
    int exp_gray;
    int hd;
    exp_gray = m_cnt[i] ^ (m_cnt[i] >> 1);
    check($sformatf("w%0d_bin", m_wid[i]), b, 16'(m_cnt[i]));
    check($sformatf("w%0d_gray", m_wid[i]), o, 16'(exp_gray));
    check($sformatf("w%0d_ovf", m_wid[i]), 16'(ov), 16'(m_ovf[i]));
    check($sformatf("w%0d_unf", m_wid[i]), 16'(un), 16'(m_unf[i]));
    check($sformatf("w%0d_wrap", m_wid[i]), 16'(wr), 16'(m_wrp[i]));
    if (ham_ok) begin
      hd = $countones(prev_out[i] ^ o);
      check($sformatf("w%0d_hamming", m_wid[i]), 16'((hd <= 1) ? 0 : hd), 16'd0);
    end
    prev_out[i] = o;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic cyc(input logic rst, input logic en, input logic up, input logic ld,
                     input logic [3:0] lv, input logic clr);
    int mx, oe, ue;
    bit ham;
    Reset = rst; En = en; Up = up; Load = ld; LoadVal = lv; FlagClr = clr;
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      mx = (1 << m_wid[i]) - 1;
      oe = 0; ue = 0;
      if (rst) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_wrp[i] = 0;
      end else begin
        if (ld) m_cnt[i] = int'(lv) & mx;
        else if (en && up) begin
          if (m_cnt[i] == mx) begin oe = 1; m_cnt[i] = m_sat[i] ? mx : 0; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else if (en && !up) begin
          if (m_cnt[i] == 0) begin ue = 1; m_cnt[i] = m_sat[i] ? 0 : mx; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
        m_ovf[i] = (oe != 0 || (m_ovf[i] != 0 && !clr)) ? 1 : 0;
        m_unf[i] = (ue != 0 || (m_unf[i] != 0 && !clr)) ? 1 : 0;
        m_wrp[i] = (oe != 0 || ue != 0) ? 1 : 0;
      end
    end
    #1;
    ham = have_prev && !rst && !ld;
    check_inst(0, 16'(out3), 16'(bin3), ovf3, unf3, wrp3, ham);
    check_inst(1, 16'(out4), 16'(bin4), ovf4, unf4, wrp4, ham);
    have_prev = 1'b1;
    $display("cyc rst=%0b en=%0b up=%0b ld=%0b lv=%0d clr=%0b | w3 bin=%0d gray=%0h o/u/w=%0b%0b%0b | w4 bin=%0d gray=%0h o/u/w=%0b%0b%0b",
             rst, en, up, ld, lv, clr, bin3, out3, ovf3, unf3, wrp3, bin4, out4, ovf4, unf4, wrp4);
  endtask

  initial begin
    logic [2:0] seq [8];
    logic [3:0] lv;
    int r;
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // 1: full up cycle through the Gray sequence, then wrap with overflow.
    cyc(1, 0, 0, 0, 0, 0);
    check("t1_reset_gray", 16'(out3), 16'(seq[0]));
    for (int k = 1; k < 8; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      check($sformatf("t1_gray%0d", k), 16'(out3), 16'(seq[k]));
    end
    cyc(0, 1, 1, 0, 0, 0);
    check("t1_wrap_gray", 16'(out3), 16'd0);
    check("t1_wrap", 16'(wrp3), 16'd1);
    check("t1_ovf", 16'(ovf3), 16'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_wrap_drop", 16'(wrp3), 16'd0);
    check("t1_ovf_sticky", 16'(ovf3), 16'd1);

    // 2: down step from zero wraps to MAX.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("t2_bin", 16'(bin3), 16'd7);
    check("t2_gray", 16'(out3), 16'b100);
    check("t2_unf", 16'(unf3), 16'd1);
    check("t2_wrap", 16'(wrp3), 16'd1);

    // 3: saturating 4-bit counter holds at 15 and strobes Wrap each attempt.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd15, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      check("t3_bin", 16'(bin4), 16'd15);
      check("t3_ovf", 16'(ovf4), 16'd1);
      check("t3_wrap", 16'(wrp4), 16'd1);
    end

    // 4: load beats enable; flags untouched.
    cyc(0, 1, 1, 1, 4'd5, 0);
    check("t4_bin", 16'(bin3), 16'd5);
    check("t4_gray", 16'(out3), 16'b111);
    check("t4_ovf4_kept", 16'(ovf4), 16'd1);
    check("t4_wrap", 16'(wrp4), 16'd0);

    // 5: set event wins over a same-cycle clear, clear alone then drops the flag.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd7, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd7, 0);
    cyc(0, 1, 1, 0, 0, 1);
    check("t5_ovf_set_wins", 16'(ovf3), 16'd1);
    cyc(0, 0, 0, 0, 0, 1);
    check("t5_ovf_cleared", 16'(ovf3), 16'd0);

    // 6: reset mid-count discards everything.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0, 0);
    check("t6_pre_bin", 16'(bin3), 16'd6);
    cyc(1, 1, 1, 0, 0, 0);
    check("t6_bin", 16'(bin3), 16'd0);
    check("t6_gray", 16'(out3), 16'd0);
    check("t6_wrap", 16'(wrp3), 16'd0);

    // Randomised traffic biased toward the terminal counts.
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 3));
      lv = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : (r == 2) ? 4'd7 : 4'($urandom);
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          ($urandom_range(0, 9) == 0),
          lv,
          ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
